// File: rtl/conv_seq_ctrl.sv
// Serial K*K MAC walk per output pixel; each pixel is presented filter_size+1 cycles after its MAC run starts.
// The WRITE state holds the pixel while pix_ready is low. MAC progress stalls until the pixel is accepted.
module conv_seq_ctrl #(
  parameter int filter_demension = 3,
  parameter int stride = 1,
  parameter int input_demension = 5,
  parameter int width = 4,
  localparam int out_demension = (input_demension - filter_demension) / stride + 1,
  localparam int filter_size = filter_demension * filter_demension,
  localparam int input_size = input_demension * input_demension,
  localparam int out_size = out_demension * out_demension,
  localparam int acc_width = 2 * width + $clog2(filter_size),
  localparam int idx_width = (out_size > 1) ? $clog2(out_size) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [filter_size*width-1:0]        filter,
  input  logic [input_size*width-1:0]         image,
  output logic                                busy,
  output logic                                pix_valid,
  input  logic                                pix_ready,
  output logic signed [acc_width-1:0]         pix_data,
  output logic [idx_width-1:0]                pix_index,
  output logic [out_size*acc_width-1:0]       ans,
  output logic                                done
);

  localparam int kw = (filter_demension > 1) ? $clog2(filter_demension) : 1;
  localparam int ow = (out_demension > 1) ? $clog2(out_demension) : 1;
  localparam logic [kw-1:0] k_last = kw'(filter_demension - 1);
  localparam logic [ow-1:0] o_last = ow'(out_demension - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                   state;
  logic [input_size*width-1:0]  img_q;
  logic [filter_size*width-1:0] flt_q;
  logic [ow-1:0]                orow, ocol;
  logic [kw-1:0]                kr, kc;
  logic signed [acc_width-1:0]  acc;

  int                           img_i, flt_i, pix_i;
  logic signed [width-1:0]      img_op, flt_op;
  logic signed [2*width-1:0]    prod;
  logic signed [acc_width-1:0]  acc_next;
  logic                         last_pix;

  always_comb begin
    img_i    = (int'(orow) * stride + int'(kr)) * input_demension + int'(ocol) * stride + int'(kc);
    flt_i    = int'(kr) * filter_demension + int'(kc);
    pix_i    = int'(orow) * out_demension + int'(ocol);
    img_op   = img_q[img_i*width +: width];
    flt_op   = flt_q[flt_i*width +: width];
    prod     = img_op * flt_op;
    // Sign-extend the product explicitly; the accumulator wraps on overflow.
    acc_next = acc + {{(acc_width-2*width){prod[2*width-1]}}, prod};
    last_pix = (orow == o_last) && (ocol == o_last);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      img_q     <= '0;
      flt_q     <= '0;
      orow      <= '0;
      ocol      <= '0;
      kr        <= '0;
      kc        <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_index <= '0;
      ans       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            img_q <= image;
            flt_q <= filter;
            acc   <= '0;
            orow  <= '0;
            ocol  <= '0;
            kr    <= '0;
            kc    <= '0;
            busy  <= 1'b1;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_next;
          if (kc == k_last) begin
            kc <= '0;
            if (kr == k_last) begin
              kr        <= '0;
              pix_data  <= acc_next;
              pix_index <= idx_width'(pix_i);
              pix_valid <= 1'b1;
              state     <= S_WRITE;
            end else begin
              kr <= kr + 1'b1;
            end
          end else begin
            kc <= kc + 1'b1;
          end
        end
        S_WRITE: begin
          if (pix_ready) begin
            ans[int'(pix_index)*acc_width +: acc_width] <= pix_data;
            pix_valid <= 1'b0;
            acc       <= '0;
            if (last_pix) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              if (ocol == o_last) begin
                ocol <= '0;
                orow <= orow + 1'b1;
              end else begin
                ocol <= ocol + 1'b1;
              end
              state <= S_MAC;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: default 5x5/3x3 instance plus a 7x7 stride-2 instance.
module tb_conv_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, pix_ready;
  logic [35:0]  filter;
  logic [99:0]  image;
  logic         busy, pix_valid, done;
  logic [11:0]  pix_data;
  logic [3:0]   pix_index;
  logic [107:0] ans;

  logic         start2, pix_ready2;
  logic [35:0]  filter2;
  logic [195:0] image2;
  logic         busy2, pix_valid2, done2;
  logic [11:0]  pix_data2;
  logic [3:0]   pix_index2;
  logic [107:0] ans2;

  conv_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .filter(filter), .image(image),
    .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_index(pix_index), .ans(ans), .done(done)
  );

  conv_seq_ctrl #(.filter_demension(3), .stride(2), .input_demension(7), .width(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .filter(filter2), .image(image2),
    .busy(busy2), .pix_valid(pix_valid2), .pix_ready(pix_ready2), .pix_data(pix_data2),
    .pix_index(pix_index2), .ans(ans2), .done(done2)
  );

  int errors = 0;
  int checks = 0;

  logic [11:0] got_data [9];
  int          got_idx  [9];
  int          got_edge [9];
  int          n_got;
  int          done_edge;
  int          hold_err;

  // Pulses start, then records every transfer (and the edge it lands on) until done or a cycle budget.
  task automatic run_frame(input logic [99:0] img, input logic [35:0] flt,
                           input int stall_pix, input int stall_n);
    int e;
    int stalled;
    logic [11:0] hd;
    logic [3:0]  hi;
    e = 0; stalled = 0; hd = '0; hi = '0;
    n_got = 0; done_edge = -1; hold_err = 0;
    image = img; filter = flt; pix_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_edge < 0 && e < 400) begin
      @(posedge clk); e++; #1;
      if (done) done_edge = e;
      if (pix_valid) begin
        if (int'(pix_index) == stall_pix && stalled < stall_n) begin
          if (stalled == 0) begin
            hd = pix_data; hi = pix_index;
          end else if (pix_data !== hd || pix_index !== hi) begin
            hold_err++;
          end
          stalled++;
          pix_ready = 1'b0;
        end else begin
          if (stalled > 0 && int'(pix_index) == stall_pix && (pix_data !== hd || pix_index !== hi))
            hold_err++;
          pix_ready = 1'b1;
          if (n_got < 9) begin
            got_data[n_got] = pix_data;
            got_idx[n_got]  = int'(pix_index);
            got_edge[n_got] = e + 1;
          end
          n_got++;
        end
      end
    end
    pix_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; pix_ready = 1'b1; image = '0; filter = '0;
    start2 = 1'b0; pix_ready2 = 1'b1; image2 = '0; filter2 = '0;
    #2;
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %b want 0", pix_valid); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (pix_data !== 12'h0 || pix_index !== 4'h0)
      begin errors++; $display("FAIL reset_pix: got %h/%h want 000/0", pix_data, pix_index); end
    checks++; if (ans !== 108'h0)     begin errors++; $display("FAIL reset_ans: got %h want 0", ans); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_frame({25{4'h1}}, {9{4'h1}}, -1, 0);
    checks++; if (n_got !== 9) begin errors++; $display("FAIL basic_count: got %0d want 9", n_got); end
    for (int p = 0; p < 9; p++) begin
      checks++;
      if (got_idx[p] !== p || got_data[p] !== 12'h009 || got_edge[p] !== 10 * (p + 1)) begin
        errors++;
        $display("FAIL basic_pix%0d: got idx %0d data %h edge %0d want idx %0d data 009 edge %0d",
                 p, got_idx[p], got_data[p], got_edge[p], p, 10 * (p + 1));
      end
    end
    checks++; if (done_edge !== 90) begin errors++; $display("FAIL basic_done_edge: got %0d want 90", done_edge); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_in_done: got %b want 1", busy); end
    checks++; if (ans !== {9{12'h009}}) begin errors++; $display("FAIL basic_ans: got %h want all 009", ans); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL basic_idle: got busy %b done %b want 0 0", busy, done); end
  endtask

  // Start is raised in the first IDLE cycle after DONE.
  task automatic test_back_to_back();
    run_frame({25{4'h7}}, {9{4'hF}}, -1, 0);
    for (int p = 0; p < 9; p++) begin
      checks++;
      if (p >= n_got || got_data[p] !== 12'hFC1 || got_idx[p] !== p) begin
        errors++;
        $display("FAIL b2b_pix%0d: got data %h idx %0d want FC1 idx %0d", p, got_data[p], got_idx[p], p);
      end
    end
    checks++; if (done_edge !== 90) begin errors++; $display("FAIL b2b_done_edge: got %0d want 90", done_edge); end
    checks++; if (ans !== {9{12'hFC1}}) begin errors++; $display("FAIL b2b_ans: got %h want all FC1", ans); end
    @(posedge clk); #1;
  endtask

  task automatic test_center();
    logic [99:0] img;
    logic [35:0] flt;
    logic [11:0] exp_v [9];
    exp_v = '{12'd6, 12'd7, 12'd0, 12'd3, 12'd4, 12'd5, 12'd0, 12'd1, 12'd2};
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        img[(r*5+c)*4 +: 4] = 4'((r * 5 + c) % 8);
    flt = '0;
    flt[16 +: 4] = 4'h1;
    run_frame(img, flt, -1, 0);
    for (int p = 0; p < 9; p++) begin
      checks++;
      if (p >= n_got || got_data[p] !== exp_v[p]) begin
        errors++;
        $display("FAIL center_pix%0d: got %h want %h", p, got_data[p], exp_v[p]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    run_frame({25{4'h1}}, {9{4'h1}}, 3, 5);
    checks++; if (hold_err !== 0) begin errors++; $display("FAIL bp_hold: got %0d changes want 0", hold_err); end
    checks++; if (got_edge[3] !== 45) begin errors++; $display("FAIL bp_pix3_edge: got %0d want 45", got_edge[3]); end
    checks++; if (got_edge[4] !== 55) begin errors++; $display("FAIL bp_pix4_edge: got %0d want 55", got_edge[4]); end
    checks++; if (done_edge !== 95) begin errors++; $display("FAIL bp_done_edge: got %0d want 95", done_edge); end
    checks++; if (n_got !== 9 || got_data[3] !== 12'h009 || got_data[8] !== 12'h009)
      begin errors++; $display("FAIL bp_data: got n %0d p3 %h p8 %h want 9 009 009", n_got, got_data[3], got_data[8]); end
    @(posedge clk); #1;
  endtask

  task automatic test_restart_reset();
    int e;
    int seen;
    e = 0; seen = 0; n_got = 0;
    image = {25{4'h1}}; filter = {9{4'h1}}; pix_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (e < 44) begin
      @(posedge clk); e++; #1;
      if (e == 29) begin start = 1'b1; image = {25{4'h7}}; end
      if (e == 30) start = 1'b0;
      if (pix_valid) begin
        if (n_got < 9) got_data[n_got] = pix_data;
        n_got++;
      end
    end
    checks++; if (n_got !== 4) begin errors++; $display("FAIL restart_count: got %0d want 4", n_got); end
    checks++; if (got_data[0] !== 12'h009 || got_data[3] !== 12'h009)
      begin errors++; $display("FAIL restart_data: got p0 %h p3 %h want 009 009", got_data[0], got_data[3]); end
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || pix_valid !== 1'b0 || ans !== 108'h0)
      begin errors++; $display("FAIL async_reset: got busy %b valid %b ans %h want 0 0 0", busy, pix_valid, ans); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      if (pix_valid || done || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", seen); end
  endtask

  function automatic int model2(input int p);
    int orow, ocol, s;
    logic signed [3:0] a, b;
    orow = p / 3; ocol = p % 3; s = 0;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++) begin
        a = image2[((orow*2+kr)*7 + ocol*2+kc)*4 +: 4];
        b = filter2[(kr*3+kc)*4 +: 4];
        s += int'(a) * int'(b);
      end
    return s;
  endfunction

  task automatic test_stride();
    int e;
    int n2;
    int d2;
    logic [11:0] g2 [9];
    int ge2 [9];
    e = 0; n2 = 0; d2 = -1;
    for (int i = 0; i < 49; i++) image2[i*4 +: 4] = 4'(i % 8);
    for (int k = 0; k < 9; k++) filter2[k*4 +: 4] = 4'(k - 4);
    pix_ready2 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    while (d2 < 0 && e < 400) begin
      @(posedge clk); e++; #1;
      if (done2) d2 = e;
      if (pix_valid2) begin
        if (n2 < 9) begin g2[n2] = pix_data2; ge2[n2] = e + 1; end
        n2++;
      end
    end
    checks++; if (n2 !== 9 || d2 !== 90) begin errors++; $display("FAIL stride_frame: got n %0d done %0d want 9 90", n2, d2); end
    checks++; if (g2[0] !== 12'd20) begin errors++; $display("FAIL stride_p0: got %h want 014", g2[0]); end
    for (int p = 0; p < 9; p++) begin
      checks++;
      if (p >= n2 || g2[p] !== 12'(model2(p)) || ge2[p] !== 10 * (p + 1)) begin
        errors++;
        $display("FAIL stride_pix%0d: got %h edge %0d want %h edge %0d", p, g2[p], ge2[p], 12'(model2(p)), 10 * (p + 1));
      end
    end
    checks++; if (ans2[8*12 +: 12] !== 12'(model2(8)))
      begin errors++; $display("FAIL stride_ans8: got %h want %h", ans2[8*12 +: 12], 12'(model2(8))); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_center();
    test_backpressure();
    test_restart_reset();
    test_stride();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
Serial convolution controller and datapath sequencer. It time-multiplexes one signed multiply-accumulate unit over every output pixel of a valid (no-padding) 2-D convolution. It latches a flattened image and filter on start, walks output rows/columns and kernel rows/columns with counters, and streams each finished pixel over a valid/ready handshake. It also builds the packed result bus for downstream logic. It is the low-area alternative to the fully parallel 3x3 multiplier array.

Parameters:
filter_demension, 3, kernel side K
stride, 1, window step S
input_demension, 5, image side N
width, 4, signed operand width W
(local) out_demension = (N-K)/S+1; filter_size = K*K; input_size = N*N; acc_width = 2*W + clog2(filter_size) (12 at defaults)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  request a convolution; sampled only in IDLE
filter  in  filter_size*W  packed signed kernel; element k = kr*K+kc at [k*W +: W]
image  in  input_size*W  packed signed image; element i = r*N+c at [i*W +: W]
busy  out  1  high from the cycle after start is accepted until return to IDLE
pix_valid  out  1  pix_data/pix_index valid
pix_ready  in  1  downstream accepts the pixel
pix_data  out  acc_width  signed convolution result
pix_index  out  clog2(out_demension^2)  pixel number p = orow*out_demension+ocol
ans  out  out_demension^2*acc_width  packed results; pixel p at [p*acc_width +: acc_width]
done  out  1  one-cycle pulse after the last pixel is transferred

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All counters, accumulator, latched operands, busy, pix_valid, pix_data, pix_index, ans and done are 0.
- States: IDLE, MAC, WRITE, DONE.
- IDLE: if start=1 at edge T, latch image and filter, clear accumulator, zero orow/ocol/kr/kc, then go to MAC.
- MAC: one product per edge: acc += sext(img[(orow*S+kr)*N + ocol*S+kc]) * sext(flt[kr*K+kc]). Signed multiply, sign-extended to acc_width, wrap-around add (no saturation). kc increments first, then kr. After the filter_size-th MAC, load pix_data=acc and pix_index=p, assert pix_valid, and go to WRITE.
- WRITE: hold pix_valid, pix_data and pix_index stable while pix_ready=0. On an edge with pix_ready=1:
  - write pix_data into the ans slot for pixel p
  - deassert pix_valid
  - clear acc
  - if p is the last pixel, go to DONE; otherwise advance ocol (then orow) and go to MAC.
- DONE: done=1 for exactly one cycle, busy=1; next edge goes to IDLE, busy=0.
- Latency with pix_ready tied high: pixel p transfers at edge T+(filter_size+1)*(p+1). At defaults the last transfer is T+90, done is high in the cycle after T+90, and IDLE is reached at T+91.
- start while not in IDLE is ignored. Input buses changing during operation have no effect, because operands are latched.
- ans retains the previous run's values until each slot is overwritten. It is never cleared by start, only by reset.
- Reset mid-run aborts immediately: no further pix_valid and no done.
- Back-to-back: a start in the IDLE cycle immediately after DONE is accepted.

Test Plan:
1. Defaults, image all 4'h1, filter all 4'h1, pix_ready=1, start pulse -> pix_index 0..8 each with pix_data=9 at edges T+10, T+20 … T+90; done high in the cycle after T+90; every ans slot = 12'h009.
2. Image all 4'h7, filter all 4'hF (-1) -> every pix_data = -63 (12'hFC1).
3. Image pixel value = (r*5+c) mod 8, filter center-only 4'h1 (others 0) -> pixel p(orow,ocol) = value at (orow+1, ocol+1), e.g. p0=6, p8=2.
4. Backpressure: pix_ready low for 5 cycles at pixel 3 -> pix_valid/pix_data/pix_index held constant, no MAC progress, done delayed by exactly 5 cycles.
5. start re-pulsed at T+30 with different image -> ignored; results match the first latched image. Reset low at T+45 -> busy, pix_valid and ans go 0 asynchronously; no done.
6. Parameters N=7, S=2, K=3, ramp image -> 3x3 output, window origins at (0,0), (0,2), (0,4), (2,0) …; results match a software model.
